// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register command sequencer.
// Holds the mode encodings, the FSM state type, default widths and the LFSR
// tap table used when SHIFT_SEQ_LFSR_SI_EN is defined.
package shift_seq_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_CNT_W = 3;

    // Shift register mode encodings (shared with the downstream register)
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_ROR  = 2'b10;
    localparam logic [1:0] MODE_SHL  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Fibonacci feedback mask: bit k set means stage k feeds the XOR.
    // Entries are maximal-length trinomials/pentanomials for small widths.
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        logic [31:0] taps;
        case (w)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;  // x^4 + x^3 + 1
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            default: taps = (32'h1 << (w - 1)) | (32'h1 << (w - 2));
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/shift_seq_lfsr.sv
// Serial-in pattern generator for shift-left commands.
// Fibonacci LFSR, seeded to 1 on reset, advancing one step per cycle with adv=1.
// Ports: clk, rst (async active-high), adv (step enable), bit_out (current MSB).
// Only instantiated when SHIFT_SEQ_LFSR_SI_EN is defined.
module shift_seq_lfsr
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic bit_out
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    // Shift toward the MSB, feeding back the XOR of the tapped stages
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= WIDTH'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_out = lfsr_q[WIDTH-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer feeding a 4-bit mode-controlled shift register.
// Accepts load / rotate-right / shift-left commands with a repeat count over a
// valid/ready handshake, drives m/d/si for cnt+1 cycles, then returns to hold.
// Keeps shadow_q equal to what the shift register will contain and pulses done
// on the last execute cycle of each command.
// Ports: clk, rst (async active-high); cmd_valid/cmd_ready handshake with
// cmd_op, cmd_data, cmd_si, cmd_cnt; outputs m, d, si, done, shadow_q.
// Optional macro SHIFT_SEQ_LFSR_SI_EN: si for shift-left comes from an LFSR.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_si,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [1:0]       m,
    output logic [WIDTH-1:0] d,
    output logic             si,
    output logic             done,
    output logic [WIDTH-1:0] shadow_q
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       m_q, m_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             si_q, si_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] shadow_d;
    logic             accept_c;
    logic             shl_bit_c;

    assign accept_c = cmd_valid && ready_q;

`ifdef SHIFT_SEQ_LFSR_SI_EN
    logic lfsr_bit;
    logic lfsr_adv_c;

    // One LFSR step per shift-left execute cycle
    assign lfsr_adv_c = (state_q == EXEC) && (m_q == MODE_SHL);

    shift_seq_lfsr #(
        .WIDTH (WIDTH)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .adv     (lfsr_adv_c),
        .bit_out (lfsr_bit)
    );

    // During shift-left the register sees the LFSR flop directly
    assign shl_bit_c = lfsr_bit;
    assign si        = (m_q == MODE_SHL) ? lfsr_bit : si_q;
`else
    assign shl_bit_c = si_q;
    assign si        = si_q;
`endif

    assign m         = m_q;
    assign d         = d_q;
    assign done      = done_q;
    assign cmd_ready = ready_q;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            m_q      <= MODE_HOLD;
            d_q      <= '0;
            si_q     <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            m_q      <= m_d;
            d_q      <= d_d;
            si_q     <= si_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            shadow_q <= shadow_d;
        end
    end

    // Next state: hold commands never leave IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c && (cmd_op != MODE_HOLD)) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (rem_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        rem_d    = rem_q;
        m_d      = m_q;
        d_d      = d_q;
        si_d     = si_q;
        done_d   = 1'b0;
        ready_d  = 1'b0;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                m_d     = MODE_HOLD;
                d_d     = '0;
                si_d    = 1'b0;
                ready_d = 1'b1;
                if (accept_c) begin
                    // ready drops for a cycle so it never coincides with done
                    ready_d = 1'b0;
                    rem_d   = cmd_cnt;
                    if (cmd_op == MODE_HOLD) begin
                        done_d = 1'b1;
                    end else begin
                        m_d    = cmd_op;
                        d_d    = cmd_data;
                        si_d   = cmd_si;
                        done_d = (cmd_cnt == '0);
                    end
                end
            end
            EXEC: begin
                // Mirror the shift register's update on this same edge
                case (m_q)
                    MODE_LOAD: shadow_d = d_q;
                    MODE_SHL:  shadow_d = {shadow_q[WIDTH-2:0], shl_bit_c};
                    MODE_ROR:  shadow_d = {shadow_q[0], shadow_q[WIDTH-1:1]};
                    default:   shadow_d = shadow_q;
                endcase
                if (rem_q == '0) begin
                    m_d     = MODE_HOLD;
                    d_d     = '0;
                    si_d    = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    rem_d  = rem_q - CNT_W'(1);
                    done_d = (rem_q == CNT_W'(1));
                end
            end
            default: begin
                m_d = MODE_HOLD;
            end
        endcase
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Command sequencer directly upstream of the 4-bit mode-controlled shift register.
- Accepts one command per valid/ready handshake: load, shift-left or rotate-right, with a repeat count.
- Drives the register's m/d/si inputs cycle by cycle, then returns them to hold.
- Keeps a shadow copy of the expected register contents and pulses done when each command finishes.

Parameters:
- WIDTH, 4, data width of d/si path and shadow register; must match the shift register.
- CNT_W, 3, width of repeat-count field; a command runs cmd_cnt+1 cycles (1..2^CNT_W).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  2  operation: 00 hold, 01 load, 10 rotate right, 11 shift left.
- cmd_data  in  WIDTH  load value, used only for op 01.
- cmd_si  in  1  serial-in bit, used only for op 11.
- cmd_cnt  in  CNT_W  repeat count minus one.
- m  out  2  mode to shift register.
- d  out  WIDTH  parallel data to shift register.
- si  out  1  serial in to shift register.
- done  out  1  one-cycle pulse on the last execute cycle of a command.
- shadow_q  out  WIDTH  predicted shift register contents.

Behaviour:
- Reset (async, rst=1): state IDLE; m=00, d=0, si=0, done=0, shadow_q=0, cmd_ready=0 while rst is high. Outputs are registered.
- States: IDLE, EXEC.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op/data/si/cnt and set remaining=cmd_cnt.
  - Next cycle: EXEC, with m=cmd_op, d=cmd_data, si=cmd_si.
- Op 00 accepted: treated as a no-op. done pulses the next cycle and the block stays IDLE. m stays 00.
- EXEC:
  - cmd_ready=0. m/d/si hold the latched values.
  - Each cycle, shadow_q updates exactly as the shift register will on that same edge:
    - load: shadow_q=d.
    - shift left: shadow_q={shadow_q[WIDTH-2:0],si}.
    - rotate right: shadow_q={shadow_q[0],shadow_q[WIDTH-1:1]}.
  - remaining decrements each cycle.
  - When remaining==0: done=1 that cycle; next cycle state IDLE with m=00, d=0, si=0.
- Latency:
  - Handshake at edge N puts m valid from edge N to edge N+1.
  - A command occupies cnt+1 cycles of m≠00.
  - At least one hold cycle (m=00) separates consecutive commands; cmd_ready rises in that hold cycle.
- Load with cnt>0 repeats the load; harmless, and shadow_q remains cmd_data.
- Counter wrap: cmd_cnt all-ones gives 2^CNT_W cycles; remaining never underflows.
- cmd_valid while cmd_ready=0 is ignored. The command is not latched, and the source must hold it.
- Reset mid-EXEC aborts immediately: m=00 and shadow_q=0. This matches the shift register, which shares rst.
- done and cmd_ready are never both 1 in the same cycle.

Optional Feature:
- Macro SHIFT_SEQ_LFSR_SI_EN.
- Defined:
  - A WIDTH-bit Fibonacci LFSR (seed 1 on reset; taps x^4+x^3+1 for WIDTH=4) supplies si during shift-left commands instead of the latched cmd_si.
  - The LFSR advances once per shift-left EXEC cycle only.
  - shadow_q uses the LFSR bit.
- Undefined: si comes from the latched cmd_si and no LFSR logic exists.

Decomposition:
- Package shift_seq_pkg holds:
  - Mode constants MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_ROR=2'b10, MODE_SHL=2'b11.
  - State enum {IDLE, EXEC}.
  - Default WIDTH/CNT_W.
- Sub-module shift_seq_lfsr (clk, rst, adv, bit_out) is instantiated only when SHIFT_SEQ_LFSR_SI_EN is defined.
- Top contains the FSM, counter and shadow register.

Test Plan:
- Reset: assert rst mid-run -> m=00, d=0, si=0, shadow_q=0, done=0 immediately, without waiting for clk. After release, cmd_ready=1 next cycle.
- Load: op=01, data=4'b1011, cnt=0 -> m=01 and d=1011 for exactly 1 cycle, done pulses that cycle, then m=00. shadow_q=1011.
- Shift left: after load 1011, op=11, si=0, cnt=0 -> shadow_q=0110. Then op=11, si=1, cnt=0 -> shadow_q=1101. m=11 for one cycle each, with a hold cycle between.
- Rotate right: after shadow_q=1101, op=10, cnt=1 -> m=10 for 2 cycles, shadow_q=1110 then 0111, done on the 2nd cycle.
- Wrap count: op=10, cnt=3'b111 on 4'b0001 -> 8 cycles of m=10, shadow_q back to 0001, single done pulse. cmd_valid held throughout stays unaccepted until cmd_ready.
- LFSR (macro defined): load 0000, then op=11, cnt=3 -> si sequence follows the LFSR from seed 0001, and shadow_q matches a bench model of the shift register bit-for-bit.
